// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   MIPS fetch stage. It holds the fetch PC and a synchronous instruction RAM
//   that is written through a program-load port. It resolves JR/JALR, J/JAL and
//   BEQ/BNE redirects in that priority order. An architectural branch delay
//   slot is optional. Stall and halt are handled here, and a NOP (all zeros) is
//   presented to decode while no real instruction is available.
//
// Ports
//   i_clock, i_reset          clock (rising edge), synchronous active-low reset
//   i_valid, i_stall          global advance enable, hazard stall
//   i_branch/i_jump_inm/i_jump_rs, i_inm_i, i_inm_j, i_rs
//                             redirect requests for the instruction on o_pc
//   i_load_we/addr/data       program RAM write port (always active)
//   o_instruction, o_pc, o_pc_plus4, o_valid, o_halt
//                             IF/ID outputs; o_halt is sticky until reset
module instruction_fetch_unit #(
    parameter int                   NB_PC       = 32,
    parameter int                   NB_INSTR    = 32,
    parameter int                   NB_INM_I    = 16,
    parameter int                   NB_INM_J    = 26,
    parameter int                   NB_ADDR     = 10,
    parameter logic [NB_PC-1:0]     RESET_PC    = '0,
    parameter int                   DELAY_SLOT  = 0,
    parameter logic [NB_INSTR-1:0]  HALT_OPCODE = '1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_branch,
    input  logic                 i_jump_inm,
    input  logic                 i_jump_rs,
    input  logic [NB_INM_I-1:0]  i_inm_i,
    input  logic [NB_INM_J-1:0]  i_inm_j,
    input  logic [NB_PC-1:0]     i_rs,
    input  logic                 i_load_we,
    input  logic [NB_ADDR-1:0]   i_load_addr,
    input  logic [NB_INSTR-1:0]  i_load_data,
    output logic [NB_INSTR-1:0]  o_instruction,
    output logic [NB_PC-1:0]     o_pc,
    output logic [NB_PC-1:0]     o_pc_plus4,
    output logic                 o_valid,
    output logic                 o_halt
);

    logic [NB_INSTR-1:0] mem [2**NB_ADDR];

    logic [NB_PC-1:0]   fetch_pc;
    logic               pending;
    logic [NB_PC-1:0]   pending_target;

    logic               adv;
    logic               redirect_req;
    logic               take_now;
    logic               start_pending;
    logic [NB_PC-1:0]   offset_ext;
    logic [NB_PC-1:0]   target;
    logic [NB_PC-1:0]   read_pc;
    logic [NB_ADDR-1:0] ram_addr;

    assign o_pc_plus4 = o_pc + NB_PC'(4);

    always_comb begin
        adv          = i_valid & ~i_stall & ~o_halt;
        redirect_req = o_valid & (i_jump_rs | i_jump_inm | i_branch);
        offset_ext   = {{(NB_PC-NB_INM_I){i_inm_i[NB_INM_I-1]}}, i_inm_i};

        if (i_jump_rs)
            target = i_rs & ~NB_PC'(3);
        else if (i_jump_inm)
            target = {o_pc_plus4[NB_PC-1:NB_INM_J+2], i_inm_j, 2'b00};
        else
            target = o_pc_plus4 + (offset_ext << 2);

        // Without a delay slot the redirect is taken immediately. With one,
        // the sequential word is fetched first and the target is parked until
        // the next advance. Requests made while a target is parked are dropped.
        take_now      = (DELAY_SLOT == 0) & redirect_req;
        start_pending = (DELAY_SLOT != 0) & redirect_req & ~pending;

        if (pending)
            read_pc = pending_target;
        else if (take_now)
            read_pc = target;
        else
            read_pc = fetch_pc;

        ram_addr = read_pc[NB_ADDR+1:2];
    end

    // The load port is not gated by reset or by adv. The read below sees the
    // pre-write contents of the same address (read-first).
    always_ff @(posedge i_clock) begin
        if (i_load_we)
            mem[i_load_addr] <= i_load_data;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            fetch_pc       <= RESET_PC;
            o_pc           <= RESET_PC;
            o_instruction  <= '0;
            o_valid        <= 1'b0;
            o_halt         <= 1'b0;
            pending        <= 1'b0;
            pending_target <= '0;
        end else if (adv) begin
            o_instruction <= mem[ram_addr];
            o_pc          <= read_pc;
            o_valid       <= 1'b1;
            o_halt        <= (mem[ram_addr] == HALT_OPCODE);
            fetch_pc      <= read_pc + NB_PC'(4);
            pending       <= start_pending;
            if (start_pending)
                pending_target <= target;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//   Drives two fetch units from the same stimulus. dut0 has no delay slot and
//   dut1 has a delay slot. An architectural model predicts the outputs of each
//   unit after every edge and queues the prediction. A monitor pops the
//   prediction and compares it with the DUT outputs just after each edge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n, vld, stl, br, ji, jr, we;
    logic [15:0] inm_i;
    logic [25:0] inm_j;
    logic [31:0] rs, wd;
    logic [9:0]  wa;

    logic [31:0] o_instr [2];
    logic [31:0] o_pc    [2];
    logic [31:0] o_pc4   [2];
    logic        o_valid [2];
    logic        o_halt  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.DELAY_SLOT(0)) dut0 (
        .i_clock(clk), .i_reset(rst_n), .i_valid(vld), .i_stall(stl),
        .i_branch(br), .i_jump_inm(ji), .i_jump_rs(jr),
        .i_inm_i(inm_i), .i_inm_j(inm_j), .i_rs(rs),
        .i_load_we(we), .i_load_addr(wa), .i_load_data(wd),
        .o_instruction(o_instr[0]), .o_pc(o_pc[0]), .o_pc_plus4(o_pc4[0]),
        .o_valid(o_valid[0]), .o_halt(o_halt[0])
    );

    instruction_fetch_unit #(.DELAY_SLOT(1)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_valid(vld), .i_stall(stl),
        .i_branch(br), .i_jump_inm(ji), .i_jump_rs(jr),
        .i_inm_i(inm_i), .i_inm_j(inm_j), .i_rs(rs),
        .i_load_we(we), .i_load_addr(wa), .i_load_data(wd),
        .o_instruction(o_instr[1]), .o_pc(o_pc[1]), .o_pc_plus4(o_pc4[1]),
        .o_valid(o_valid[1]), .o_halt(o_halt[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem [1024];
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic        m_valid [2];
    logic        m_halt  [2];
    logic        m_pend  [2];
    logic [31:0] m_tgt   [2];

    // The architectural rule is as follows. The next presented PC is the
    // redirect target (DS0), or pc+4 followed by the target (DS1). A unit that
    // has not presented any PC yet starts at address 0.
    task automatic model_step();
        exp_t        e;
        logic [31:0] p4, tgt, npc;
        logic        r;
        int          off;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_pc[d] = 0; m_instr[d] = 0; m_valid[d] = 0; m_halt[d] = 0; m_pend[d] = 0;
            end else if (vld && !stl && !m_halt[d]) begin
                p4  = m_pc[d] + 32'd4;
                off = int'($signed(inm_i));
                if (jr)      tgt = {rs[31:2], 2'b00};
                else if (ji) tgt = {p4[31:28], inm_j, 2'b00};
                else         tgt = p4 + 32'(off * 4);
                r = m_valid[d] && (jr || ji || br);
                if (!m_valid[d]) npc = 32'd0;
                else if (d == 0) npc = r ? tgt : p4;
                else if (m_pend[d]) begin
                    npc = m_tgt[d];
                    m_pend[d] = 0;
                end else begin
                    npc = p4;
                    if (r) begin m_pend[d] = 1; m_tgt[d] = tgt; end
                end
                m_pc[d]    = npc;
                m_instr[d] = mem[npc[11:2]];
                m_valid[d] = 1;
                m_halt[d]  = (m_instr[d] == HALT);
            end
            e.pc = m_pc[d]; e.instr = m_instr[d]; e.valid = m_valid[d]; e.halt = m_halt[d];
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (we) mem[wa] = wd;
    endtask

    // ---------------- monitor ----------------
    function automatic void chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 && q0.size() > 0) || (d == 1 && q1.size() > 0)) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("pc",     d, o_pc[d],    e.pc);
                    chk("pc4",    d, o_pc4[d],   e.pc + 32'd4);
                    chk("instr",  d, o_instr[d], e.instr);
                    chk("valid",  d, 32'(o_valid[d]), 32'(e.valid));
                    chk("halt",   d, 32'(o_halt[d]),  32'(e.halt));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic quiet();
        br = 0; ji = 0; jr = 0; we = 0; stl = 0;
    endtask

    task automatic run_until(int d, logic [31:0] pc);
        for (int i = 0; i < 200; i++) begin
            if (m_valid[d] && m_pc[d] == pc) return;
            cycle();
        end
        checks++;
        failures++;
        $display("FAIL run_until dut%0d: pc %h never reached", d, pc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; vld = 0; inm_i = 0; inm_j = 0; rs = 0; wa = 0; wd = 0;
        quiet();
        @(negedge clk);

        // Program RAM under reset. No word is HALT, and word 3 gets a marker.
        we = 1;
        for (int a = 0; a < 1024; a++) begin
            wa = 10'(a);
            wd = $urandom & 32'hFFFF_FFFE;
            cycle();
        end
        wa = 10'd3; wd = 32'h1234_5678; cycle();
        we = 0; cycle();

        // Sequential fetch. A same-cycle write to word 2 leaves the old word
        // visible in the fetch.
        rst_n = 1; vld = 1;
        run_until(0, 32'h4);
        we = 1; wa = 10'd2; wd = 32'hCAFE_0000; cycle(); we = 0;
        run_until(0, 32'h8);
        stl = 1; cycle(3); stl = 0;
        vld = 0; cycle(3); vld = 1;
        cycle(2);

        // A negative branch and the priority of simultaneous redirects.
        run_until(0, 32'h10);
        br = 1; inm_i = 16'hFFFC; cycle(); quiet(); cycle(2);
        jr = 1; rs = 32'h40; ji = 1; inm_j = 26'h20; br = 1; cycle(); quiet(); cycle(2);
        jr = 1; rs = 32'h1000; cycle(); quiet(); cycle(3);

        // Delay slot behaviour. The redirect raised in the slot is dropped.
        rst_n = 0; cycle(); rst_n = 1;
        run_until(1, 32'h20);
        ji = 1; inm_j = 26'h10; cycle(); quiet();
        jr = 1; rs = 32'h80; cycle(); quiet(); cycle(3);

        // Sticky halt, followed by recovery through reset.
        rst_n = 0; we = 1; wa = 10'd5; wd = HALT; cycle(); we = 0; cycle();
        rst_n = 1; cycle(20);
        rst_n = 0; cycle(); rst_n = 1; cycle(4);
        we = 1; wa = 10'd5; wd = 32'h0; cycle(); we = 0;

        // Randomized traffic with occasional resets, loads and HALT words.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom % 50) != 0;
            vld   = ($urandom % 5) != 0;
            stl   = ($urandom % 5) == 0;
            br    = ($urandom % 4) == 0;
            ji    = ($urandom % 6) == 0;
            jr    = ($urandom % 6) == 0;
            inm_i = 16'($urandom);
            inm_j = 26'($urandom);
            rs    = ($urandom % 2) ? $urandom : ($urandom % 256);
            we    = ($urandom % 6) == 0;
            wa    = ($urandom % 2) ? 10'($urandom) : 10'($urandom % 64);
            wd    = (($urandom % 30) == 0) ? HALT : ($urandom & 32'hFFFF_FFFE);
            cycle();
        end
        quiet(); rst_n = 1; vld = 1;
        cycle(2);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain: q0=%0d q1=%0d expected 0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Parametrised MIPS fetch stage.
- Holds the fetch PC and an internal synchronous instruction RAM with a program-load port.
- Resolves J/JAL, JR/JALR and BEQ/BNE redirects with fixed priority, with an optional architectural branch delay slot.
- Supports hazard stall, sticky HALT detection and NOP injection toward decode.
- Sits between the debug/loader unit and the IF/ID boundary.

Parameters:
NB_PC, 32, PC and i_rs width.
NB_INSTR, 32, instruction width.
NB_INM_I, 16, branch offset width (signed, word units).
NB_INM_J, 26, jump index width.
NB_ADDR, 10, RAM word-address width; depth = 2**NB_ADDR.
RESET_PC, 0, fetch address after reset.
DELAY_SLOT, 0, 0 = redirect with no delay slot; 1 = the instruction after a branch/jump always executes.
HALT_OPCODE, 32'hFFFF_FFFF, instruction word that halts fetch.

Ports:
i_clock  in  1  clock, all state on rising edge.
i_reset  in  1  synchronous, active-low reset.
i_valid  in  1  global advance enable (debug step/run).
i_stall  in  1  hazard stall; holds all state.
i_branch  in  1  taken branch for the instruction on o_pc.
i_jump_inm  in  1  J/JAL for the instruction on o_pc.
i_jump_rs  in  1  JR/JALR for the instruction on o_pc.
i_inm_i  in  NB_INM_I  branch offset.
i_inm_j  in  NB_INM_J  jump index.
i_rs  in  NB_PC  register jump target.
i_load_we  in  1  program RAM write strobe.
i_load_addr  in  NB_ADDR  program RAM word address.
i_load_data  in  NB_INSTR  program RAM write data.
o_instruction  out  NB_INSTR  instruction to decode, or 0 (NOP) when o_valid=0.
o_pc  out  NB_PC  byte address of o_instruction.
o_pc_plus4  out  NB_PC  o_pc+4, used as the link value.
o_valid  out  1  o_instruction is a real fetched instruction.
o_halt  out  1  sticky; HALT_OPCODE has reached o_instruction.

Behaviour:
- Reset (i_reset=0 at edge): fetch_pc=RESET_PC; o_pc=RESET_PC; o_instruction=0; o_valid=0; o_halt=0; pending=0. RAM contents are not cleared.
- Advance condition: adv = i_valid & ~i_stall & ~o_halt. When adv=0, all registers hold, redirect inputs are ignored, and the RAM read is not enabled.
- Redirect targets, computed relative to o_pc:
  - JR: {i_rs[NB_PC-1:2], 2'b00}.
  - J: {o_pc_plus4[NB_PC-1:28], i_inm_j, 2'b00}.
  - Branch: o_pc_plus4 + (sign-extended i_inm_i << 2), computed modulo 2**NB_PC.
- Redirect priority is jump_rs > jump_inm > branch. Redirects are only honoured when o_valid=1.
- DELAY_SLOT=0, on adv:
  - read_pc = redirect ? target : fetch_pc.
  - RAM is read at read_pc[NB_ADDR+1:2]; upper address bits are ignored, so the address wraps.
  - Next edge: o_instruction<=RAM data, o_pc<=read_pc, o_valid<=1, fetch_pc<=read_pc+4.
  - Result: zero-bubble redirect; o_pc+4 is never presented.
- DELAY_SLOT=1, on adv with a redirect:
  - read_pc=fetch_pc (the delay slot); latch target and set pending=1.
  - On the next adv: read_pc=target, pending<=0.
  - A redirect asserted while pending=1 is ignored (decode never issues one from a delay slot).
- Latency: 1 cycle from read_pc to o_instruction. First valid output arrives on the first adv edge after reset release.
- Halt: on the edge where HALT_OPCODE is loaded into o_instruction, o_halt<=1 with o_valid=1. Every register freezes afterwards until reset.
- Load port: write on any edge with i_load_we=1, independent of adv; it still writes during reset. A same-cycle read of the same address returns the old data (read-first).
- Reset asserted mid-operation overrides adv, redirect, pending and halt.

Test Plan:
- RAM[0..3]={A,B,C,D}; release reset with i_valid=1 -> cycle 1: o_valid=1, o_pc=0, instr=A; then o_pc=4/B, 8/C, 12/D; o_pc_plus4 tracks o_pc+4.
- i_stall=1 for 3 cycles while o_pc=8 -> o_pc=8 and instr=C held for 3 cycles, resume at 12; i_valid=0 behaves identically.
- DELAY_SLOT=0, o_pc=0x10, i_branch=1, i_inm_i=16'hFFFC -> next o_pc=0x04. With i_jump_rs=1, i_rs=0x40, i_jump_inm=1, i_inm_j=0x20 all asserted together -> next o_pc=0x40 (JR wins).
- DELAY_SLOT=1, o_pc=0x20, i_jump_inm=1, i_inm_j=0x10 -> o_pc sequence 0x24 then 0x40. A redirect asserted while o_pc=0x24 is ignored.
- RAM[5]=HALT_OPCODE -> o_halt=1 when o_pc=0x14; o_pc stays 0x14 for 10 cycles. i_reset=0 clears o_halt, o_valid=0, o_pc=RESET_PC.
- Load 0x1234_5678 at address 3 during reset, then run -> o_pc=12 shows 0x1234_5678. JR to 0x1000 with NB_ADDR=10 -> wraps and fetches RAM word 0 while o_pc=0x1000.
